// File: rtl/seq_detect_prog_pkg.sv
// Shared constants, reset defaults and helpers for the programmable sequence detector.
package seq_detect_prog_pkg;

    localparam int unsigned MASK_W = 32;

    localparam logic MODE_OVERLAP = 1'b1;
    localparam logic MODE_NONOVL  = 1'b0;

    localparam logic [MASK_W-1:0] DEF_PATTERN = 32'h0000_000D;
    localparam int unsigned       DEF_LEN     = 4;
    localparam int unsigned       MIN_LEN     = 2;

    // Per-cycle decision of the merged RUN / LOAD_CHECK config machine.
    typedef enum logic [1:0] {
        CFG_RUN      = 2'd0,
        CFG_LOAD_OK  = 2'd1,
        CFG_LOAD_BAD = 2'd2
    } cfg_action_e;

    // Mask with the low len bits set.
    function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
        logic [MASK_W-1:0] m;
        if (len >= MASK_W) begin
            m = '1;
        end else begin
            m = (32'd1 << len) - 32'd1;
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_hit_counter.sv
// Saturating match counter with sticky saturation flag and synchronous clear.
module seq_hit_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Clear dominates a same-cycle increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (clear) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
            if (count == (CNT_MAX - CNT_W'(1))) begin
                sat <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial bit-pattern detector with overlap control,
// bit-valid qualifier, config validation and a saturating hit counter.
module seq_detect_prog
    import seq_detect_prog_pkg::*;
#(
    parameter int unsigned        MAX_LEN     = 8,
    parameter int unsigned        LEN_W       = 4,
    parameter int unsigned        CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(DEF_PATTERN),
    parameter logic [LEN_W-1:0]   RST_LEN     = LEN_W'(DEF_LEN),
    parameter logic               RST_OVERLAP = MODE_OVERLAP
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic               din,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               clear,
    output logic               hit,
    output logic [CNT_W-1:0]   hit_count,
    output logic               count_sat,
    output logic               cfg_err
);

    localparam logic [LEN_W-1:0] MIN_LEN_L = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    logic [MAX_LEN-1:0] hist_q;
    logic [LEN_W-1:0]   fill_q;

    cfg_action_e        cfg_action;
    logic               len_legal;
    logic [MAX_LEN-1:0] hist_shift;
    logic [LEN_W-1:0]   fill_inc;
    logic [MAX_LEN-1:0] mask;
    logic               match;
    logic [MAX_LEN-1:0] hist_d;
    logic [LEN_W-1:0]   fill_d;

    // Config decode: a load takes the whole cycle, legal or not.
    always_comb begin
        cfg_action = CFG_RUN;
        len_legal  = (cfg_len >= MIN_LEN_L) && (cfg_len <= MAX_LEN_L);
        if (cfg_load) begin
            cfg_action = len_legal ? CFG_LOAD_OK : CFG_LOAD_BAD;
        end
    end

    // Shift/fill next-state and the compare against the masked pattern.
    always_comb begin
        hist_shift = {hist_q[MAX_LEN-2:0], din};
        fill_inc   = (fill_q < len_q) ? (fill_q + LEN_W'(1)) : fill_q;
        mask       = MAX_LEN'(len_mask(32'(len_q)));
        match      = (cfg_action == CFG_RUN) && en && (fill_inc >= len_q) &&
                     (((hist_shift ^ pattern_q) & mask) == '0);
        hist_d     = hist_q;
        fill_d     = fill_q;
        case (cfg_action)
            CFG_LOAD_OK: begin
                hist_d = '0;
                fill_d = '0;
            end
            CFG_LOAD_BAD: begin
                hist_d = hist_q;
                fill_d = fill_q;
            end
            default: begin
                if (en) begin
                    hist_d = hist_shift;
                    fill_d = (match && (overlap_q == MODE_NONOVL)) ? '0 : fill_inc;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern_q <= RST_PATTERN;
            len_q     <= RST_LEN;
            overlap_q <= RST_OVERLAP;
        end else if (cfg_action == CFG_LOAD_OK) begin
            pattern_q <= cfg_pattern;
            len_q     <= cfg_len;
            overlap_q <= cfg_overlap;
        end
    end

    // Sticky error: set by a rejected load, cleared only by an accepted one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_err <= 1'b0;
        end else if (cfg_action == CFG_LOAD_OK) begin
            cfg_err <= 1'b0;
        end else if (cfg_action == CFG_LOAD_BAD) begin
            cfg_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= '0;
            fill_q <= '0;
            hit    <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            hit    <= match;
        end
    end

    seq_hit_counter #(
        .CNT_W (CNT_W)
    ) u_hit_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (match),
        .clear   (clear),
        .count   (hit_count),
        .sat     (count_sat)
    );

endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: directed vector table, corner-case sequences and
// random traffic against a queue-based reference model (8-bit and 3-bit counters).
module tb_seq_detect_prog;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic       din;
    logic       cfg_load;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       clear;

    logic       hit;
    logic [7:0] hit_count;
    logic       count_sat;
    logic       cfg_err;
    logic       hit3;
    logic [2:0] hit_count3;
    logic       count_sat3;
    logic       cfg_err3;

    seq_detect_prog dut (
        .clk(clk), .reset_n(reset_n), .en(en), .din(din), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .clear(clear), .hit(hit), .hit_count(hit_count), .count_sat(count_sat),
        .cfg_err(cfg_err)
    );

    seq_detect_prog #(.CNT_W(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .en(en), .din(din), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .clear(clear), .hit(hit3), .hit_count(hit_count3), .count_sat(count_sat3),
        .cfg_err(cfg_err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: config plus the list of valid bits since the last flush.
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ov;
    bit         m_seq[$];
    bit         m_hit;
    int         m_cnt;
    bit         m_sat;
    int         m_cnt3;
    bit         m_sat3;
    bit         m_err;

    int checks;
    int errors;

    typedef struct {
        logic       en;
        logic       din;
        logic       load;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ov;
        logic       clr;
        logic       e_hit;
        int         e_cnt;
        logic       e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int e, int d, int ld, int p, int l, int o, int c,
                                int eh, int ec, int ee);
        vec_t v;
        v.en = 1'(e);  v.din = 1'(d);  v.load = 1'(ld);
        v.pat = 8'(p); v.len = 4'(l);  v.ov = 1'(o);  v.clr = 1'(c);
        v.e_hit = 1'(eh); v.e_cnt = ec; v.e_err = 1'(ee);
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pat = 8'b0000_1101;
        m_len = 4;
        m_ov  = 1'b1;
        m_seq.delete();
        m_hit = 1'b0;
        m_cnt = 0;  m_sat = 1'b0;
        m_cnt3 = 0; m_sat3 = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_step();
        bit match;
        match = 1'b0;
        if (cfg_load) begin
            if (cfg_len >= 2 && cfg_len <= 8) begin
                m_pat = cfg_pattern;
                m_len = int'(cfg_len);
                m_ov  = cfg_overlap;
                m_seq.delete();
                m_err = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end else if (en) begin
            m_seq.push_back(din);
            if (m_seq.size() > 8) void'(m_seq.pop_front());
            if (m_seq.size() >= m_len) begin
                match = 1'b1;
                for (int k = 0; k < m_len; k++) begin
                    if (m_seq[m_seq.size() - m_len + k] != m_pat[m_len - 1 - k]) match = 1'b0;
                end
            end
            if (match && !m_ov) m_seq.delete();
        end
        m_hit = match;
        if (clear) begin
            m_cnt = 0; m_sat = 1'b0; m_cnt3 = 0; m_sat3 = 1'b0;
        end else if (match) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt == 255) m_sat = 1'b1;
            if (m_cnt3 < 7) m_cnt3++;
            if (m_cnt3 == 7) m_sat3 = 1'b1;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".hit"},        int'(hit),        int'(m_hit));
        check({tag, ".hit_count"},  int'(hit_count),  m_cnt);
        check({tag, ".count_sat"},  int'(count_sat),  int'(m_sat));
        check({tag, ".cfg_err"},    int'(cfg_err),    int'(m_err));
        check({tag, ".hit3"},       int'(hit3),       int'(m_hit));
        check({tag, ".hit_count3"}, int'(hit_count3), m_cnt3);
        check({tag, ".count_sat3"}, int'(count_sat3), int'(m_sat3));
        check({tag, ".cfg_err3"},   int'(cfg_err3),   int'(m_err));
    endtask

    // Called at posedge+1: drive, take the edge, step the model, compare at posedge+1.
    task automatic drive(input logic e, input logic d, input logic ld,
                         input logic [7:0] p, input logic [3:0] l,
                         input logic o, input logic c, input string tag);
        en = e; din = d; cfg_load = ld; cfg_pattern = p; cfg_len = l;
        cfg_overlap = o; clear = c;
        @(posedge clk);
        model_step();
        #1;
        compare_all(tag);
    endtask

    task automatic bit_in(input logic d, input string tag);
        drive(1'b1, d, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, tag);
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o,
                        input logic c, input string tag);
        drive(1'b0, 1'b0, 1'b1, p, l, o, c, tag);
    endtask

    localparam int P = 8'b0000_1101;

    initial begin
        logic [7:0] aa;
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        en = 1'b0; din = 1'b0; cfg_load = 1'b0; cfg_pattern = '0;
        cfg_len = '0; cfg_overlap = 1'b0; clear = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        check("reset.hit_count_zero", int'(hit_count), 0);
        reset_n = 1'b1;

        // en din ld pat len ov clr | hit cnt err
        tbl.push_back(mk(1,1,0,0,0,0,0, 0,0,0));
        tbl.push_back(mk(1,1,0,0,0,0,0, 0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0));
        tbl.push_back(mk(1,1,0,0,0,0,0, 1,1,0));
        tbl.push_back(mk(1,1,0,0,0,0,0, 0,1,0));
        tbl.push_back(mk(1,0,0,0,0,0,0, 0,1,0));
        tbl.push_back(mk(1,1,0,0,0,0,0, 1,2,0));
        tbl.push_back(mk(0,0,1,P,4,0,0, 0,2,0));
        tbl.push_back(mk(1,1,0,0,0,0,0, 0,2,0));
        tbl.push_back(mk(1,1,0,0,0,0,0, 0,2,0));
        tbl.push_back(mk(1,0,0,0,0,0,0, 0,2,0));
        tbl.push_back(mk(1,1,0,0,0,0,0, 1,3,0));
        tbl.push_back(mk(1,1,0,0,0,0,0, 0,3,0));
        tbl.push_back(mk(1,0,0,0,0,0,0, 0,3,0));
        tbl.push_back(mk(1,1,0,0,0,0,0, 0,3,0));
        tbl.push_back(mk(1,0,1,P,4,0,0, 0,3,0));
        tbl.push_back(mk(1,1,0,0,0,0,0, 0,3,0));
        tbl.push_back(mk(1,1,0,0,0,0,0, 0,3,0));
        tbl.push_back(mk(0,1,0,0,0,0,0, 0,3,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,3,0));
        tbl.push_back(mk(0,1,0,0,0,0,0, 0,3,0));
        tbl.push_back(mk(1,0,0,0,0,0,0, 0,3,0));
        tbl.push_back(mk(1,1,0,0,0,0,0, 1,4,0));
        tbl.push_back(mk(0,1,0,0,0,0,0, 0,4,0));
        tbl.push_back(mk(0,0,1,3,1,1,0, 0,4,1));
        tbl.push_back(mk(0,0,1,3,9,1,0, 0,4,1));
        tbl.push_back(mk(1,1,0,0,0,0,0, 0,4,1));
        tbl.push_back(mk(1,1,0,0,0,0,0, 0,4,1));
        tbl.push_back(mk(1,0,0,0,0,0,0, 0,4,1));
        tbl.push_back(mk(1,1,0,0,0,0,0, 1,5,1));
        tbl.push_back(mk(1,1,0,0,0,0,0, 0,5,1));
        tbl.push_back(mk(1,1,0,0,0,0,0, 0,5,1));
        tbl.push_back(mk(1,0,0,0,0,0,0, 0,5,1));
        tbl.push_back(mk(1,1,0,0,0,0,1, 1,0,1));
        tbl.push_back(mk(0,0,1,3,2,1,0, 0,0,0));
        tbl.push_back(mk(1,1,0,0,0,0,0, 0,0,0));
        tbl.push_back(mk(1,1,0,0,0,0,0, 1,1,0));
        tbl.push_back(mk(1,1,0,0,0,0,0, 1,2,0));
        tbl.push_back(mk(1,1,1,3,2,1,0, 0,2,0));
        tbl.push_back(mk(1,1,0,0,0,0,0, 0,2,0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].en, tbl[i].din, tbl[i].load, tbl[i].pat, tbl[i].len,
                  tbl[i].ov, tbl[i].clr, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d.hit_vec", i),   int'(hit),       int'(tbl[i].e_hit));
            check($sformatf("tbl%0d.count_vec", i), int'(hit_count), tbl[i].e_cnt);
            check($sformatf("tbl%0d.err_vec", i),   int'(cfg_err),   int'(tbl[i].e_err));
        end

        // Reconfigure to a long pattern while a partial match of the old one is pending.
        load(8'(P), 4'd4, 1'b1, 1'b0, "reconf_ld1");
        bit_in(1'b1, "reconf_p"); bit_in(1'b1, "reconf_p"); bit_in(1'b0, "reconf_p");
        load(8'hAA, 4'd8, 1'b1, 1'b0, "reconf_ld2");
        bit_in(1'b1, "reconf_tail");
        check("reconf_no_false_hit", int'(hit), 0);
        aa = 8'hAA;
        for (int b = 7; b >= 0; b--) bit_in(aa[b], "reconf_aa");
        check("reconf_full_hit", int'(hit), 1);
        load(8'h01, 4'd1, 1'b0, 1'b0, "reconf_bad");
        check("reconf_cfg_err", int'(cfg_err), 1);
        for (int b = 7; b >= 0; b--) bit_in(aa[b], "reconf_old");
        check("reconf_old_still_hits", int'(hit), 1);

        // Saturation of the 3-bit counter, then clear coinciding with a match.
        load(8'h03, 4'd2, 1'b1, 1'b1, "sat_ld");
        for (int n = 0; n < 10; n++) bit_in(1'b1, "sat_ones");
        check("sat_count3", int'(hit_count3), 7);
        check("sat_flag3",  int'(count_sat3), 1);
        check("sat_count8", int'(hit_count), 9);
        drive(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, "sat_clr");
        check("clr_hit_pulse",  int'(hit), 1);
        check("clr_count3",     int'(hit_count3), 0);
        check("clr_sat3",       int'(count_sat3), 0);

        // Asynchronous reset in the middle of a cycle with a partial match pending.
        load(8'(P), 4'd4, 1'b1, 1'b0, "ar_ld");
        bit_in(1'b1, "ar_p"); bit_in(1'b1, "ar_p"); bit_in(1'b0, "ar_p"); bit_in(1'b1, "ar_p");
        check("ar_pre_hit", int'(hit), 1);
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("ar_hit_now",   int'(hit), 0);
        check("ar_count_now", int'(hit_count), 0);
        check("ar_sat_now",   int'(count_sat), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        compare_all("ar_held");
        bit_in(1'b1, "ar_s"); bit_in(1'b0, "ar_s"); bit_in(1'b1, "ar_s");
        check("ar_no_stale_hit", int'(hit), 0);
        bit_in(1'b1, "ar_f"); bit_in(1'b1, "ar_f"); bit_in(1'b0, "ar_f"); bit_in(1'b1, "ar_f");
        check("ar_fresh_hit", int'(hit), 1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic       e, d, ld, o, c;
            logic [7:0] p;
            logic [3:0] l;
            ld = ($urandom_range(0, 39) == 0);
            p  = 8'($urandom);
            l  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(2, 4));
            o  = 1'($urandom_range(0, 1));
            c  = ($urandom_range(0, 59) == 0);
            e  = ($urandom_range(0, 3) != 0);
            d  = 1'($urandom_range(0, 1));
            drive(e, d, ld, p, l, o, c, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
